// File: rtl/rv32e_inst_encoder.sv
// rv32e_inst_encoder
//   Packs RV32E instruction fields into 32-bit instruction words (inverse of
//   the decoder). Bundles that cannot be represented are replaced by a NOP
//   (addi x0,x0,0) and flagged on a sideband bit. A small circular FIFO
//   between the field side and the word side absorbs backpressure.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid / in_ready   field-side handshake
//   in_format             0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   in_opcode/funct3/funct7, in_rd/rs1/rs2, in_imm   instruction fields
//   out_valid / out_ready word-side handshake
//   out_encoded, out_error  head-of-buffer word and its error flag
//   error_count           saturating count of errored accepts
//   word_count            wrapping count of popped words
module rv32e_inst_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_format,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_encoded,
    output logic             out_error,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] word_count
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    // An immediate fits when every bit above the field's sign bit is a copy
    // of it, i.e. the upper slice is all ones or all zeros.
    logic imm_fits_12, imm_fits_13, imm_fits_21;
    assign imm_fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign imm_fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign imm_fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    logic [31:0] enc_word;
    logic        enc_err;

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        // RV32E has 16 registers; bit 4 set means x16..x31. Only the
        // register fields a format actually uses are checked.
        unique case (in_format)
            FMT_R: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_err  = in_rd[4] | in_rs1[4] | in_rs2[4];
            end
            FMT_I: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_err  = in_rd[4] | in_rs1[4] | ~imm_fits_12;
            end
            FMT_S: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_err  = in_rs1[4] | in_rs2[4] | ~imm_fits_12;
            end
            FMT_B: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_err  = in_rs1[4] | in_rs2[4] | ~imm_fits_13 | in_imm[0];
            end
            FMT_U: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
                enc_err  = in_rd[4] | (|in_imm[11:0]);
            end
            FMT_J: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, in_opcode};
                enc_err  = in_rd[4] | ~imm_fits_21 | in_imm[0];
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) enc_word = NOP_WORD;
    end

    // ------------------------------------------------------------------
    // Output buffer: circular FIFO, pointers carry an extra wrap bit so
    // full and empty are distinguishable with equal indices.
    // ------------------------------------------------------------------
    logic [AW:0]             wr_ptr, rd_ptr;
    logic [DEPTH-1:0][31:0]  buf_word;
    logic [DEPTH-1:0]        buf_err;
    logic                    empty, full, push, pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // in_ready depends on registered pointers only, never on out_ready.
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Outputs read as zero while empty so the post-reset view is clean.
    assign out_encoded = empty ? 32'h0 : buf_word[rd_ptr[AW-1:0]];
    assign out_error   = empty ? 1'b0  : buf_err[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            error_count <= '0;
            word_count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                word_count <= word_count + 1'b1;
            end
            if (push && enc_err && (error_count != {CNT_W{1'b1}}))
                error_count <= error_count + 1'b1;
        end
    end

    // Storage needs no reset: an empty buffer is never read.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            buf_word[wr_ptr[AW-1:0]] <= enc_word;
            buf_err[wr_ptr[AW-1:0]]  <= enc_err;
        end
    end

endmodule
